// File: rtl/msx_mem_mapper_if.sv
// CPU-side bus and external-RAM handshake bundle for the MSX2 memory mapper.
// master = CPU/RAM environment, slave = mapper.
interface msx_mem_mapper_if #(
    parameter int SEG_BITS = 3
);
    logic                  cen;
    logic [15:0]           addr;
    logic [7:0]            din;
    logic [7:0]            dout;
    logic                  io_oe;
    logic                  mem_oe;
    logic                  mreq_n;
    logic                  iorq_n;
    logic                  rd_n;
    logic                  wr_n;
    logic                  m1_n;
    logic                  rfrsh_n;
    logic                  en;
    logic                  wait_n;
    logic [SEG_BITS+13:0]  mem_addr;
    logic                  mem_req;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic                  mem_ack;
    logic [7:0]            mem_rdata;

    modport slave (
        input  cen, addr, din, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n, en,
               mem_ack, mem_rdata,
        output dout, io_oe, mem_oe, wait_n, mem_addr, mem_req, mem_we, mem_wdata
    );

    modport master (
        output cen, addr, din, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n, en,
               mem_ack, mem_rdata,
        input  dout, io_oe, mem_oe, wait_n, mem_addr, mem_req, mem_we, mem_wdata
    );
endinterface

// File: rtl/msx_mem_mapper.sv
// MSX2 page-segment mapper + RAM wait controller; MAPPER_M1_WAIT_EN adds the extra M1 wait.
// Latency: mem_req 1 clk after cycle detect; wait_n releases 1 clk after mem_ack.
// Backpressure: CPU is stalled via wait_n until the RAM acknowledges.
module msx_mem_mapper #(
    parameter int          SEG_BITS  = 3,
    parameter logic [7:0]  PORT_BASE = 8'hFC
) (
    input  logic           clk,
    input  logic           reset,
    msx_mem_mapper_if.slave bus
);
    localparam int AW = SEG_BITS + 14;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [SEG_BITS-1:0] page_q [4];
    logic [SEG_BITS-1:0] page_d [4];
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                io_wr_q, io_wr_d;
`ifdef MAPPER_M1_WAIT_EN
    logic                m1_q, m1_d;
    logic                hold_q, hold_d;
`endif

    logic       io_sel, io_wr, io_rd, mem_start, wait_c;
    logic [7:0] io_dat;
    logic       unused_ok;

    assign io_sel    = ~bus.iorq_n & bus.m1_n & (bus.addr[7:2] == PORT_BASE[7:2]);
    assign io_wr     = io_sel & ~bus.wr_n;
    assign io_rd     = io_sel & ~bus.rd_n & ~reset;
    assign mem_start = ~bus.mreq_n & bus.rfrsh_n & bus.en & (~bus.rd_n | ~bus.wr_n);
    assign unused_ok = ^{bus.cen, bus.din};

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        mem_addr_d = mem_addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        io_wr_d    = io_wr;
        wait_c     = 1'b1;
`ifdef MAPPER_M1_WAIT_EN
        m1_d       = m1_q;
        hold_d     = hold_q;
`endif
        // Register write fires only on the first clk of the qualified strobe.
        if (io_wr && !io_wr_q) begin
            page_d[bus.addr[1:0]] = bus.din[SEG_BITS-1:0];
        end

        case (state_q)
            IDLE: begin
                wait_c = ~mem_start;
                if (mem_start) begin
                    state_d    = REQ;
                    mem_addr_d = {page_q[bus.addr[15:14]], bus.addr[13:0]};
                    we_d       = ~bus.wr_n;
                    wdata_d    = bus.din;
`ifdef MAPPER_M1_WAIT_EN
                    m1_d       = ~bus.m1_n;
`endif
                end
            end
            REQ: begin
                wait_c  = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                wait_c = 1'b0;
                if (bus.mem_ack) begin
                    if (!we_q) rdata_d = bus.mem_rdata;
                    state_d = DONE;
`ifdef MAPPER_M1_WAIT_EN
                    hold_d  = m1_q;
`endif
                end
            end
            DONE: begin
`ifdef MAPPER_M1_WAIT_EN
                wait_c = ~hold_q;
                if (bus.cen) hold_d = 1'b0;
`endif
                if (bus.mreq_n) begin
                    state_d = IDLE;
`ifdef MAPPER_M1_WAIT_EN
                    hold_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        io_dat                 = '1;
        io_dat[SEG_BITS-1:0]   = page_q[bus.addr[1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int i = 0; i < 4; i++) page_q[i] <= SEG_BITS'(3 - i);
            mem_addr_q <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            io_wr_q    <= 1'b0;
`ifdef MAPPER_M1_WAIT_EN
            m1_q       <= 1'b0;
            hold_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            mem_addr_q <= mem_addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            io_wr_q    <= io_wr_d;
`ifdef MAPPER_M1_WAIT_EN
            m1_q       <= m1_d;
            hold_q     <= hold_d;
`endif
        end
    end

    assign bus.wait_n    = wait_c | reset;
    assign bus.mem_req   = (state_q == REQ) & ~reset;
    assign bus.mem_we    = (state_q == REQ) & we_q & ~reset;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.io_oe     = io_rd;
    assign bus.mem_oe    = (state_q == DONE) & ~bus.rd_n & ~reset;
    assign bus.dout      = io_rd ? io_dat : rdata_q;
endmodule

// File: tb/tb_msx_mem_mapper.sv
// Randomized self-checking bench for msx_mem_mapper against a page-table reference model.
module tb_msx_mem_mapper;
    localparam int SB   = 3;
    localparam int MASK = (1 << SB) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    msx_mem_mapper_if #(.SEG_BITS(SB)) bus ();
    msx_mem_mapper #(.SEG_BITS(SB), .PORT_BASE(8'hFC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int page [4];
    int last_rdata = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cen = 1'b0; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
        bus.wr_n = 1'b1; bus.m1_n = 1'b1; bus.rfrsh_n = 1'b1; bus.en = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) page[i] = (3 - i) & MASK;
        last_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_bus();
        @(negedge clk); #1;
        chk("rst_wait_n", 32'(bus.wait_n), 1);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_io_oe", 32'(bus.io_oe), 0);
        chk("rst_mem_oe", 32'(bus.mem_oe), 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic io_write(input int p, input int d);
        @(negedge clk);
        bus.addr = {8'($urandom), 8'(8'hFC | p)};
        bus.din = 8'(d); bus.iorq_n = 1'b0; bus.wr_n = 1'b0; bus.en = 1'($urandom);
        #1 chk("iow_wait_n", 32'(bus.wait_n), 1);
        @(negedge clk);
        bus.din = 8'(~d);   // still-held strobe must not re-latch
        @(negedge clk);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        page[p] = d & MASK;
    endtask

    task automatic io_read(input int p);
        @(negedge clk);
        bus.addr = {8'($urandom), 8'(8'hFC | p)};
        bus.iorq_n = 1'b0; bus.rd_n = 1'b0; bus.en = 1'($urandom);
        #1;
        chk("ior_io_oe", 32'(bus.io_oe), 1);
        chk("ior_dout", 32'(bus.dout), 256 - (1 << SB) + page[p]);
        chk("ior_wait_n", 32'(bus.wait_n), 1);
        chk("ior_mem_req", 32'(bus.mem_req), 0);
        @(negedge clk);
        bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
        #1 chk("ior_io_oe_off", 32'(bus.io_oe), 0);
    endtask

    task automatic mem_op(input int a, input bit we, input int d, input int delay,
                          input bit m1, input bit mid_io);
        int exp_addr = page[a >> 14] * 16384 + (a & 16383);
        int rd = $urandom_range(0, 255);
        int mp = $urandom_range(0, 3);
        int mv = $urandom_range(0, 255);
        @(negedge clk);
        bus.addr = 16'(a); bus.din = 8'(d); bus.mreq_n = 1'b0; bus.rfrsh_n = 1'b1;
        bus.en = 1'b1; bus.m1_n = ~m1;
        if (we) bus.wr_n = 1'b0; else bus.rd_n = 1'b0;
        #1;
        chk("detect_wait_n", 32'(bus.wait_n), 0);
        chk("detect_no_req", 32'(bus.mem_req), 0);
        @(negedge clk); #1;
        chk("req_pulse", 32'(bus.mem_req), 1);
        chk("req_addr", 32'(bus.mem_addr), exp_addr);
        chk("req_we", 32'(bus.mem_we), 32'(we));
        if (we) chk("req_wdata", 32'(bus.mem_wdata), d);
        chk("req_wait_n", 32'(bus.wait_n), 0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (mid_io && i == 0) begin
                bus.addr = 16'(16'h00FC | mp); bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
                bus.din = 8'(mv);
                page[mp] = mv & MASK;
            end else if (mid_io && i == 1) begin
                bus.addr = 16'(a); bus.iorq_n = 1'b1; bus.wr_n = ~we;
            end
            #1;
            chk("wait_no_req", 32'(bus.mem_req), 0);
            chk("wait_wait_n", 32'(bus.wait_n), 0);
            chk("wait_addr_held", 32'(bus.mem_addr), exp_addr);
        end
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'(rd);
        #1 chk("ack_wait_n", 32'(bus.wait_n), 0);
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'($urandom);
        #1;
`ifdef MAPPER_M1_WAIT_EN
        if (m1) begin
            int k = $urandom_range(0, 2);
            chk("m1_hold_entry", 32'(bus.wait_n), 0);
            for (int i = 0; i < k; i++) begin
                @(negedge clk); #1 chk("m1_hold", 32'(bus.wait_n), 0);
            end
            @(negedge clk);
            bus.cen = 1'b1;
            #1 chk("m1_hold_cen", 32'(bus.wait_n), 0);
            @(negedge clk);
            bus.cen = 1'b0;
            #1 chk("m1_release", 32'(bus.wait_n), 1);
        end else
            chk("done_wait_n", 32'(bus.wait_n), 1);
`else
        chk("done_wait_n", 32'(bus.wait_n), 1);
`endif
        if (!we) begin
            chk("done_mem_oe", 32'(bus.mem_oe), 1);
            chk("done_rdata", 32'(bus.dout), rd);
            last_rdata = rd;
        end else
            chk("done_mem_oe_wr", 32'(bus.mem_oe), 0);
        @(negedge clk);
        bus.mreq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.m1_n = 1'b1;
        #1 chk("end_mem_oe", 32'(bus.mem_oe), 0);
        @(negedge clk); #1;
        chk("idle_wait_n", 32'(bus.wait_n), 1);
        chk("idle_no_req", 32'(bus.mem_req), 0);
        chk("idle_dout", 32'(bus.dout), last_rdata);
    endtask

    // kind 0: refresh, 1: slot not selected, 2: stray ack while idle
    task automatic no_start(input int kind);
        @(negedge clk);
        bus.addr = 16'($urandom);
        bus.mreq_n = (kind == 2); bus.rd_n = 1'b0;
        bus.rfrsh_n = (kind != 0); bus.en = (kind != 1);
        bus.mem_ack = (kind == 2); bus.mem_rdata = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ns_wait_n", 32'(bus.wait_n), 1);
            chk("ns_no_req", 32'(bus.mem_req), 0);
            chk("ns_mem_oe", 32'(bus.mem_oe), 0);
            @(negedge clk);
        end
        idle_bus();
        #1 chk("ns_dout", 32'(bus.dout), last_rdata);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        bus.addr = 16'($urandom); bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.en = 1'b1;
        @(negedge clk);
        @(negedge clk);          // now in WAIT
        #1 chk("riw_pre_wait_n", 32'(bus.wait_n), 0);
        reset = 1'b1;
        bus.mreq_n = 1'b1;
        #1 chk("riw_rst_wait_n", 32'(bus.wait_n), 1);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
        #1;
        chk("riw_wait_n", 32'(bus.wait_n), 1);
        chk("riw_no_req", 32'(bus.mem_req), 0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        chk("riw_ack_ignored", 32'(bus.mem_oe), 0);
        chk("riw_dout", 32'(bus.dout), 0);
        chk("riw_no_req2", 32'(bus.mem_req), 0);
        idle_bus();
        model_reset();
        for (int p = 0; p < 4; p++) io_read(p);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.addr = 16'h0000; bus.din = 8'h00; bus.mem_rdata = 8'h00;
        idle_bus();
        repeat (2) @(negedge clk);
        do_reset();

        for (int p = 0; p < 4; p++) io_read(p);
        io_write(2, 8'h2D);
        io_read(2);
        mem_op(16'h8123, 1'b0, 0, 0, 1'b0, 1'b0);
        mem_op(16'h4000, 1'b1, 8'hA5, 6, 1'b0, 1'b0);
        no_start(0);
        no_start(1);
        no_start(2);
        mem_op(16'hC010, 1'b0, 0, 3, 1'b0, 1'b1);
        for (int p = 0; p < 4; p++) io_read(p);
        reset_in_wait();
        mem_op(16'h0100, 1'b0, 0, 0, 1'b1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int op = $urandom_range(0, 4);
            case (op)
                0: io_write($urandom_range(0, 3), $urandom_range(0, 255));
                1: io_read($urandom_range(0, 3));
                4: no_start($urandom_range(0, 2));
                default: begin
                    bit w  = 1'($urandom);
                    int dl = $urandom_range(0, 5);
                    bit m1 = !w && ($urandom_range(0, 2) == 0);
                    bit mi = !m1 && dl >= 2 && ($urandom_range(0, 1) == 1);
                    mem_op($urandom_range(0, 65535), w, $urandom_range(0, 255), dl, m1, mi);
                end
            endcase
        end
        for (int p = 0; p < 4; p++) io_read(p);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/msx_mem_mapper.md
Name: msx_mem_mapper

Overview:
- Parametrised MSX2-style memory mapper and bus-wait controller. It is the successor to the MSX1 fixed 32 KB ROM/RAM decode.
- Holds four page-segment registers at I/O ports PORT_BASE..PORT_BASE+3. It translates Z80 logical addresses into a physical address of SEG_BITS+14 bits.
- Runs a request/acknowledge handshake toward external RAM (SDRAM/BRAM arbiter) and stretches the Z80 cycle with wait_n until the RAM acknowledges.
- Sits between the T80 bus and the slot-selected RAM, next to the I/O decoder and PPI.

Parameters:
- SEG_BITS, 3, segment register width; mapped RAM = 2^SEG_BITS x 16 KB (default 128 KB); legal 1..8.
- PORT_BASE, 8'hFC, I/O address of the page-0 register; pages 1..3 at +1..+3; low 2 bits must be 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cen  in  1  CPU clock enable (3.58 MHz positive enable)
- addr  in  16  CPU address
- din  in  8  CPU data out (write data)
- dout  out  8  data to CPU (mapper read-back or RAM read data)
- io_oe  out  1  dout valid for an I/O read of a mapper register
- mem_oe  out  1  dout valid for a mapped RAM read
- mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n  in  1 each  Z80 bus strobes
- en  in  1  mapper slot selected by the slot decoder for the current memory cycle
- wait_n  out  1  to the CPU WAIT_n
- mem_addr  out  SEG_BITS+14  physical address
- mem_req  out  1  single-clock request pulse
- mem_we  out  1  write qualifier, valid with mem_req
- mem_wdata  out  8  write data, valid with mem_req
- mem_ack  in  1  RAM done; rdata valid in the same clock
- mem_rdata  in  8  RAM read data

Behaviour:
- Reset state:
  - page regs: p0=3, p1=2, p2=1, p3=0 (masked to SEG_BITS).
  - FSM IDLE; wait_n=1; mem_req=0; mem_we=0; dout=8'h00; io_oe=0; mem_oe=0.
- Register write:
  - Condition: iorq_n=0, wr_n=0, m1_n=1, addr[7:2]==PORT_BASE[7:2].
  - Latch din[SEG_BITS-1:0] into page[addr[1:0]] once, on the first clk the strobe is seen (falling-edge detect on the qualified strobe, independent of cen).
  - Upper din bits are ignored.
- Register read:
  - Condition: same decode with rd_n=0.
  - io_oe=1 combinationally while the condition holds.
  - dout = {unused upper bits forced to 1, page[addr[1:0]]}, e.g. SEG_BITS=3, page=5 -> 8'hFD.
- Memory FSM states: IDLE, REQ, WAIT, DONE.
- IDLE -> REQ:
  - Condition: mreq_n=0, rfrsh_n=1, en=1, (rd_n=0 or wr_n=0).
  - In the same clock, wait_n drops to 0 (combinational from the condition), so the CPU sees wait at its next cen.
- REQ (1 clk):
  - mem_req=1, mem_addr={page[addr[15:14]], addr[13:0]}, mem_we=~wr_n, mem_wdata=din.
  - Always go to WAIT.
- WAIT:
  - wait_n=0; mem_addr is held.
  - On mem_ack: capture mem_rdata into dout if it is a read, then go to DONE.
- DONE:
  - wait_n=1; mem_oe=1 while rd_n=0.
  - Stay until mreq_n=1, then go to IDLE.
- Latency: mem_req is asserted 1 clk after detection; wait_n releases 1 clk after mem_ack.
- Refresh cycles (rfrsh_n=0), en=0 cycles and I/O cycles never leave IDLE.
- mem_ack outside WAIT is ignored.
- A register write while the FSM is not IDLE updates the register; it does not alter the held mem_addr of the in-flight transaction.
- Reset in any state returns to IDLE in the next clk:
  - no mem_req is issued;
  - wait_n=1;
  - registers return to their reset values.

Optional Feature:
- MAPPER_M1_WAIT_EN:
  - Defined: for opcode fetches (m1_n=0 at IDLE->REQ), DONE keeps wait_n=0 until one further cen pulse has occurred after entry to DONE. This models the MSX standard extra M1 wait state.
  - Undefined: M1 fetches behave like all other reads.

Test Plan:
- Reset, then I/O read of ports FC..FF with SEG_BITS=3 -> dout FB, FA, F9, F8 with io_oe=1; wait_n=1 throughout.
- OUT (FE),8'h2D with SEG_BITS=3 -> page2=5; memory read at 0x8123 -> mem_req one clk, mem_addr=0x14123, mem_we=0.
- Memory write 0x4000=8'hA5 with mem_ack delayed 6 clks -> wait_n low from detect until 1 clk after ack; mem_wdata=A5, mem_we=1; exactly one mem_req pulse.
- Refresh cycle (mreq_n=0, rfrsh_n=0) and a cycle with en=0 -> no mem_req, wait_n stays 1; a stray mem_ack in IDLE produces no state change.
- Reset asserted in WAIT -> next clk IDLE, wait_n=1, page regs back to 3,2,1,0; a subsequent ack is ignored.
- With MAPPER_M1_WAIT_EN, M1 fetch with immediate ack -> wait_n held low one extra cen after DONE entry; without the macro -> released 1 clk after ack.
